// File: rtl/arb2x1.sv
// ---------------------------------------------------------------------------
// arb2x1 -- two-input round-robin arbiter with a one-word registered output.
//
// Two valid/ready producers compete for a single registered output slot.
// When both offer a word, the channel that did not win the previous accepted
// transfer is granted, so contention alternates 0,1,0,1,... The output
// register refills in the same cycle it drains, giving one word per cycle of
// sustained throughput with one cycle of latency.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in0_valid  channel 0 offers a word
//   in0_data   channel 0 word (WIDTH bits)
//   in0_ready  channel 0 word accepted this cycle
//   in1_valid  channel 1 offers a word
//   in1_data   channel 1 word (WIDTH bits)
//   in1_ready  channel 1 word accepted this cycle
//   out_valid  out_data holds a word for the consumer
//   out_data   registered selected word (WIDTH bits)
//   out_ready  consumer accepts out_data this cycle
//   sel        registered source of out_data (0 = in0, 1 = in1)
// ---------------------------------------------------------------------------
module arb2x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_next;
    logic   last_grant;

    logic   load_en;
    logic   any_valid;
    logic   grant_idx;
    logic   accept;

    // Grant decision depends only on the valid lines and last_grant, never on
    // data, so the ready path stays short and data-independent.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        load_en    = 1'b0;
        any_valid  = 1'b0;
        grant_idx  = 1'b0;
        accept     = 1'b0;
        in0_ready  = 1'b0;
        in1_ready  = 1'b0;
        state_next = state;

        // The slot can take a word when empty, or when the held word leaves
        // on this same edge.
        load_en   = (state == EMPTY) || out_ready;
        any_valid = in0_valid || in1_valid;

        if (in0_valid && in1_valid) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = in1_valid;
        end

        // Reset suppresses acceptance so no producer believes its word moved.
        accept = rst_n && any_valid && load_en;

        in0_ready = accept && (grant_idx == 1'b0);
        in1_ready = accept && (grant_idx == 1'b1);

        if (accept) begin
            state_next = FULL;
        end else if ((state == FULL) && out_ready) begin
            state_next = EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output word, its source and the round-robin pointer only move on an
    // accepted transfer; a drain without refill leaves them untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data   <= '0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            out_data   <= grant_idx ? in1_data : in0_data;
            sel        <= grant_idx;
            last_grant <= grant_idx;
        end
    end

    assign out_valid = (state == FULL);

endmodule
